// File: rtl/text_pixel_pipeline_if.sv
// Memory-side bus of the text pixel pipeline: VRAM word port and font ROM row port,
// both with 1-cycle synchronous reads on the memory side.
interface text_pixel_pipeline_if #(
  parameter int VRAM_AW = 11
);
  logic [VRAM_AW-1:0] vram_addr;
  logic [31:0]        vram_rdata;
  logic [10:0]        font_addr;
  logic [7:0]         font_data;

  modport master (output vram_addr, output font_addr, input vram_rdata, input font_data);
  modport slave  (input vram_addr, input font_addr, output vram_rdata, output font_data);
endinterface

// File: rtl/text_pixel_pipeline.sv
// 5-cycle text-mode pixel pipeline: VRAM cell fetch, font lookup, palette resolve.
// Optional cursor blink counter is built when TEXT_CURSOR_BLINK_EN is defined.
module text_pixel_pipeline #(
  parameter int COLS    = 80,
  parameter int ROWS    = 30,
  parameter int VRAM_AW = 11
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  input  logic [9:0]             drawX,
  input  logic [9:0]             drawY,
  input  logic                   vde_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  text_pixel_pipeline_if.master  mem,
  input  logic                   pal_we,
  input  logic [3:0]             pal_idx,
  input  logic [11:0]            pal_data,
  input  logic                   cursor_en,
  input  logic [6:0]             cursor_col,
  input  logic [4:0]             cursor_row,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue,
  output logic                   vde_out,
  output logic                   hsync_out,
  output logic                   vsync_out
);

  localparam logic [7:0] COLS_L = 8'(COLS);
  localparam logic [6:0] ROWS_L = 7'(ROWS);
  localparam int         HALF   = COLS / 2;

  typedef struct packed {
    logic       col0;
    logic [2:0] gx;
    logic [3:0] gy;
    logic       oob;
    logic       cur;
  } early_t;

  typedef struct packed {
    logic       inv;
    logic [3:0] fg;
    logic [3:0] bg;
    logic [2:0] gx;
    logic       oob;
    logic       cur;
  } late_t;

  logic [6:0]         col;
  logic [5:0]         row;
  logic               cursor_vis;
  logic [VRAM_AW-1:0] addr0;
  early_t             early0, s1, s2;
  late_t              late2, s3, s4;
  logic [15:0]        chr;
  logic [4:0][2:0]    tim_q;
  logic [11:0]        pal [16];
  logic               pix_bit;
  logic [11:0]        rgb_next;

  assign col = drawX[9:3];
  assign row = drawY[9:4];

`ifdef TEXT_CURSOR_BLINK_EN
  logic [5:0] blink_cnt;
  logic       vsync_prev;

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      blink_cnt  <= '0;
      vsync_prev <= 1'b0;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_in && !vsync_prev) blink_cnt <= blink_cnt + 6'd1;
    end
  end

  assign cursor_vis = ~blink_cnt[5];
`else
  assign cursor_vis = 1'b1;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    early0      = '0;
    early0.col0 = col[0];
    early0.gx   = drawX[2:0];
    early0.gy   = drawY[3:0];
    early0.oob  = ({1'b0, col} >= COLS_L) || ({1'b0, row} >= ROWS_L);
    early0.cur  = cursor_en && (col == cursor_col) && (row == {1'b0, cursor_row})
                  && (drawY[3:1] == 3'b111) && cursor_vis;
    addr0       = VRAM_AW'(row) * VRAM_AW'(HALF) + VRAM_AW'(col[6:1]);

    chr       = s2.col0 ? mem.vram_rdata[31:16] : mem.vram_rdata[15:0];
    late2     = '0;
    late2.inv = chr[15];
    late2.fg  = chr[7:4];
    late2.bg  = chr[3:0];
    late2.gx  = s2.gx;
    late2.oob = s2.oob;
    late2.cur = s2.cur;

    // Cursor overrides both the glyph and the invert bit.
    pix_bit  = (mem.font_data[3'd7 - s4.gx] ^ s4.inv) | s4.cur;
    rgb_next = pix_bit ? pal[s4.fg] : pal[s4.bg];
    if (!tim_q[3][2] || s4.oob) rgb_next = '0;
  end

  always_ff @(posedge axi_aclk) begin
    // NOTE: sequential state uses non-blocking assignments so all stages advance together.
    if (!axi_aresetn) begin
      mem.vram_addr       <= '0;
      mem.font_addr       <= '0;
      s1                  <= '0;
      s2                  <= '0;
      s3                  <= '0;
      s4                  <= '0;
      tim_q               <= '0;
      {red, green, blue}  <= '0;
    end else begin
      mem.vram_addr       <= addr0;
      s1                  <= early0;
      s2                  <= s1;
      mem.font_addr       <= {chr[14:8], s2.gy};
      s3                  <= late2;
      s4                  <= s3;
      tim_q               <= {tim_q[3:0], {vde_in, hsync_in, vsync_in}};
      {red, green, blue}  <= rgb_next;
    end
  end

  assign {vde_out, hsync_out, vsync_out} = tim_q[4];

  // Write lands at the end of the cycle, so a pixel resolving in the same cycle sees the old entry.
  always_ff @(posedge axi_aclk) begin
    // NOTE: the palette is a small flop array, not a RAM, so it can legally take a reset value.
    if (!axi_aresetn) begin
      for (int i = 0; i < 16; i++) pal[i] <= {3{4'(i)}};
    end else if (pal_we) begin
      pal[pal_idx] <= pal_data;
    end
  end

endmodule

// File: tb/tb_text_pixel_pipeline.sv
// Randomized and directed bench for text_pixel_pipeline against a cycle-indexed reference model.
module tb_text_pixel_pipeline;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int AW   = 11;
  localparam int HMAX = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, vde_in, hsync_in, vsync_in, pal_we, cursor_en;
  logic [9:0]  drawX, drawY;
  logic [3:0]  pal_idx, red, green, blue;
  logic [11:0] pal_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        vde_out, hsync_out, vsync_out;

  text_pixel_pipeline_if #(.VRAM_AW(AW)) mem();

  text_pixel_pipeline #(.COLS(COLS), .ROWS(ROWS), .VRAM_AW(AW)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n), .drawX(drawX), .drawY(drawY),
    .vde_in(vde_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .mem(mem),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .red(red), .green(green), .blue(blue),
    .vde_out(vde_out), .hsync_out(hsync_out), .vsync_out(vsync_out));

  logic [31:0] vram     [0:2047];
  logic [7:0]  font_rom [0:2047];

  always @(posedge clk) begin
    mem.vram_rdata <= vram[mem.vram_addr];
    mem.font_data  <= font_rom[mem.font_addr];
  end

  typedef struct {
    logic [9:0]  x, y;
    logic        v, h, s, we;
    logic [3:0]  idx;
    logic [11:0] d;
    logic        rn, cen;
    logic [6:0]  ccol;
    logic [4:0]  crow;
  } stim_t;

  typedef struct {
    bit         valid, on, blank;
    logic [3:0] fg, bg;
    logic [2:0] tim;
  } pix_t;

  stim_t       st;
  pix_t        pend    [0:HMAX-1];
  logic [11:0] exp_rgb [0:HMAX-1];
  logic [2:0]  exp_tim [0:HMAX-1];
  logic [11:0] obs_rgb [0:HMAX-1];
  logic [2:0]  obs_tim [0:HMAX-1];
  logic [11:0] mpal [16];
  int          mcnt;
  bit          mprev;
  int          cyc, checks, errors;

  function automatic pix_t model_pixel(stim_t s);
    pix_t p;
    int col, row, gx, gy;
    logic [31:0] w;
    logic [15:0] ch;
    logic [7:0]  f;
    bit in_range, vis;
    col = int'(s.x) / 8;  gx = int'(s.x) % 8;
    row = int'(s.y) / 16; gy = int'(s.y) % 16;
    in_range = (col < COLS) && (row < ROWS);
    p.valid = 1; p.on = 0; p.fg = 0; p.bg = 0;
    p.tim   = {s.v, s.h, s.s};
    p.blank = !s.v || !in_range;
    if (in_range) begin
      w  = vram[row * (COLS / 2) + col / 2];
      ch = (col % 2 == 1) ? w[31:16] : w[15:0];
      f  = font_rom[{ch[14:8], 4'(gy)}];
      p.on = f[7 - gx] ^ ch[15];
      p.fg = ch[7:4];
      p.bg = ch[3:0];
    end
    vis = 1;
`ifdef TEXT_CURSOR_BLINK_EN
    vis = (mcnt < 32);
`endif
    if (s.cen && col == int'(s.ccol) && row == int'(s.crow) && gy >= 14 && vis) p.on = 1;
    return p;
  endfunction

  task automatic apply_stim();
    drawX = st.x; drawY = st.y; vde_in = st.v; hsync_in = st.h; vsync_in = st.s;
    pal_we = st.we; pal_idx = st.idx; pal_data = st.d; rst_n = st.rn;
    cursor_en = st.cen; cursor_col = st.ccol; cursor_row = st.crow;
  endtask

  // One clock: sample outputs of this cycle, drive st, advance the model.
  task automatic tick();
    pix_t r;
    @(negedge clk);
    cyc++;
    if (cyc >= HMAX - 2) begin
      $display("FAIL cycle_budget: cycle %0d exceeds history %0d", cyc, HMAX);
      $fatal(1);
    end
    obs_rgb[cyc] = {red, green, blue};
    obs_tim[cyc] = {vde_out, hsync_out, vsync_out};
    apply_stim();
    pend[cyc] = model_pixel(st);
    exp_rgb[cyc+1] = '0; exp_tim[cyc+1] = '0;
    if (cyc >= 4 && pend[cyc-4].valid) begin
      r = pend[cyc-4];
      exp_rgb[cyc+1] = r.blank ? 12'h000 : mpal[r.on ? r.fg : r.bg];
      exp_tim[cyc+1] = r.tim;
    end
    if (!st.rn) begin
      for (int i = 0; i < 16; i++) mpal[i] = {3{4'(i)}};
      for (int k = 0; k < 4; k++) if (cyc >= k) pend[cyc-k].valid = 0;
      exp_rgb[cyc+1] = '0; exp_tim[cyc+1] = '0;
      mcnt = 0; mprev = 0;
    end else begin
      if (st.we) mpal[st.idx] = st.d;
      if (st.s && !mprev) mcnt = (mcnt + 1) % 64;
      mprev = st.s;
    end
  endtask

  task automatic idle_stim();
    st.x = 0; st.y = 0; st.v = 0; st.h = 0; st.s = 0; st.we = 0;
    st.idx = 0; st.d = 0; st.rn = 1; st.cen = 0; st.ccol = 0; st.crow = 0;
  endtask

  task automatic reset_dut();
    idle_stim();
    st.rn = 0;
    repeat (3) tick();
    st.rn = 1;
  endtask

  task automatic test_reset();
    int n;
    idle_stim();
    vram[0] = 32'h0041_8F41;
    st.v = 1; st.h = 1; st.s = 1; st.rn = 0;
    st.we = 1; st.idx = 4'd15; st.d = 12'h123;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs_rgb[cyc] !== 12'h000 || obs_tim[cyc] !== 3'b000) begin
        errors++;
        $display("FAIL reset_outputs: rgb=%h tim=%b required 000/000", obs_rgb[cyc], obs_tim[cyc]);
      end
    end
    vram[2] = 32'h0000_41F0;
    font_rom[{7'h41, 4'h0}] = 8'h80;
    idle_stim();
    st.x = 10'd32; st.v = 1;
    tick(); n = cyc;
    idle_stim();
    repeat (5) tick();
    for (int c = n; c < n + 5; c++) begin
      checks++;
      if (obs_tim[c][2] !== 1'b0) begin
        errors++;
        $display("FAIL reset_vde_hold: cycle %0d vde_out=%b required 0", c - n, obs_tim[c][2]);
      end
    end
    checks++;
    if (obs_rgb[n+5] !== 12'hFFF) begin
      errors++;
      $display("FAIL reset_pal15: rgb=%h required fff (pal_we ignored in reset)", obs_rgb[n+5]);
    end
  endtask

  task automatic test_glyph();
    int n;
    reset_dut();
    vram[0] = {16'h41F0, 16'h0000};
    font_rom[{7'h41, 4'h0}] = 8'h80;
    idle_stim();
    st.x = 10'd8; st.v = 1; tick(); n = cyc;
    st.x = 10'd9; tick();
    idle_stim(); repeat (6) tick();
    checks++;
    if (obs_rgb[n+5] !== 12'hFFF) begin
      errors++; $display("FAIL glyph_gx0: rgb=%h required fff", obs_rgb[n+5]);
    end
    checks++;
    if (obs_rgb[n+6] !== 12'h000) begin
      errors++; $display("FAIL glyph_gx1: rgb=%h required 000", obs_rgb[n+6]);
    end
    checks++;
    if (obs_tim[n+4][2] !== 1'b0 || obs_tim[n+5][2] !== 1'b1) begin
      errors++; $display("FAIL glyph_latency: vde n+4=%b n+5=%b required 0/1", obs_tim[n+4][2], obs_tim[n+5][2]);
    end
  endtask

  task automatic test_invert();
    int n;
    vram[0] = {16'hC1F0, 16'h0000};
    idle_stim();
    st.x = 10'd8; st.v = 1; tick(); n = cyc;
    st.x = 10'd9; tick();
    st.v = 0; tick();
    st.v = 1; tick();
    idle_stim(); repeat (6) tick();
    checks++;
    if (obs_rgb[n+5] !== 12'h000 || obs_rgb[n+6] !== 12'hFFF) begin
      errors++; $display("FAIL invert_swap: rgb=%h,%h required 000,fff", obs_rgb[n+5], obs_rgb[n+6]);
    end
    checks++;
    if (obs_rgb[n+7] !== 12'h000 || obs_rgb[n+8] !== 12'hFFF) begin
      errors++; $display("FAIL vde_blank_rgb: rgb=%h,%h required 000,fff", obs_rgb[n+7], obs_rgb[n+8]);
    end
    checks++;
    if (obs_tim[n+6][2] !== 1'b1 || obs_tim[n+7][2] !== 1'b0 || obs_tim[n+8][2] !== 1'b1) begin
      errors++; $display("FAIL vde_delay: vde=%b%b%b required 101", obs_tim[n+6][2], obs_tim[n+7][2], obs_tim[n+8][2]);
    end
  endtask

  task automatic test_palette_hazard();
    int n;
    reset_dut();
    vram[0] = {16'h41F0, 16'h0000};
    font_rom[{7'h41, 4'h0}] = 8'hC0;
    idle_stim();
    st.x = 10'd8; st.v = 1; tick(); n = cyc;
    st.x = 10'd9; tick();
    idle_stim(); repeat (2) tick();
    st.we = 1; st.idx = 4'd15; st.d = 12'h0F0; tick();
    idle_stim(); repeat (3) tick();
    checks++;
    if (obs_rgb[n+5] !== 12'hFFF) begin
      errors++; $display("FAIL hazard_old: rgb=%h required fff", obs_rgb[n+5]);
    end
    checks++;
    if (obs_rgb[n+6] !== 12'h0F0) begin
      errors++; $display("FAIL hazard_new: rgb=%h required 0f0", obs_rgb[n+6]);
    end
  endtask

  task automatic cursor_pixel(input logic en, input logic [9:0] y, output int n);
    idle_stim();
    st.cen = en; st.ccol = 7'd2; st.crow = 5'd3;
    st.x = 10'd19; st.y = y; st.v = 1;
    tick(); n = cyc;
  endtask

  task automatic test_cursor();
    int n0, n1, n2, nb;
    reset_dut();
    vram[3 * (COLS / 2) + 1] = {16'h0000, 16'h20F0};
    font_rom[{7'h20, 4'hF}] = 8'h00;
    font_rom[{7'h20, 4'hD}] = 8'h00;
    cursor_pixel(1'b1, 10'd63, n0);
    cursor_pixel(1'b0, 10'd63, n1);
    cursor_pixel(1'b1, 10'd61, n2);
    idle_stim(); repeat (6) tick();
    checks++;
    if (obs_rgb[n0+5] !== 12'hFFF) begin
      errors++; $display("FAIL cursor_on: rgb=%h required fff", obs_rgb[n0+5]);
    end
    checks++;
    if (obs_rgb[n1+5] !== 12'h000 || obs_rgb[n2+5] !== 12'h000) begin
      errors++; $display("FAIL cursor_off: rgb=%h,%h required 000,000", obs_rgb[n1+5], obs_rgb[n2+5]);
    end
`ifdef TEXT_CURSOR_BLINK_EN
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 32; i++) begin
        idle_stim(); st.s = 1; tick();
        st.s = 0; tick();
      end
      idle_stim(); tick();
      cursor_pixel(1'b1, 10'd63, nb);
      idle_stim(); repeat (6) tick();
      checks++;
      if (obs_rgb[nb+5] !== (p == 0 ? 12'h000 : 12'hFFF)) begin
        errors++; $display("FAIL cursor_blink_%0d: rgb=%h required %h", (p + 1) * 32, obs_rgb[nb+5],
                           (p == 0 ? 12'h000 : 12'hFFF));
      end
    end
`endif
  endtask

  task automatic rand_stim(input bit force_vde);
    idle_stim();
    if ($urandom_range(0, 1) == 1) begin
      st.x = 10'($urandom_range(0, 127)); st.y = 10'($urandom_range(0, 127));
    end else begin
      st.x = 10'($urandom_range(0, 1023)); st.y = 10'($urandom_range(0, 1023));
    end
    st.v = force_vde ? 1'b1 : ($urandom_range(0, 9) != 0);
    st.h = 1'($urandom); st.s = ($urandom_range(0, 7) == 0);
    st.we = ($urandom_range(0, 4) == 0);
    st.idx = 4'($urandom); st.d = 12'($urandom);
    st.cen = ($urandom_range(0, 3) != 0);
    st.ccol = 7'($urandom_range(0, 15)); st.crow = 5'($urandom_range(0, 7));
  endtask

  task automatic compare_range(input string name, input int first, input int last);
    for (int c = first; c <= last; c++) begin
      checks++;
      if (obs_rgb[c] !== exp_rgb[c] || obs_tim[c] !== exp_tim[c]) begin
        errors++;
        $display("FAIL %s: cycle %0d rgb=%h tim=%b required rgb=%h tim=%b",
                 name, c, obs_rgb[c], obs_tim[c], exp_rgb[c], exp_tim[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int start;
    for (int i = 0; i < 2048; i++) begin
      vram[i] = $urandom; font_rom[i] = 8'($urandom);
    end
    start = cyc;
    for (int i = 0; i < 1500; i++) begin
      rand_stim(1'b0); tick();
    end
    idle_stim(); repeat (6) tick();
    compare_range("random_pixel", start + 1, cyc);
  endtask

  task automatic test_reset_midframe();
    int r, start;
    start = cyc;
    repeat (20) begin rand_stim(1'b1); tick(); end
    repeat (2) begin rand_stim(1'b1); st.rn = 0; st.we = 1; tick(); end
    r = cyc;
    repeat (40) begin rand_stim(1'b1); tick(); end
    idle_stim(); repeat (6) tick();
    for (int c = r + 1; c <= r + 5; c++) begin
      checks++;
      if (obs_tim[c][2] !== 1'b0 || obs_rgb[c] !== 12'h000) begin
        errors++;
        $display("FAIL midframe_hold: cycle %0d vde=%b rgb=%h required 0/000", c - r, obs_tim[c][2], obs_rgb[c]);
      end
    end
    compare_range("midframe_pixel", start + 1, cyc);
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0; mcnt = 0; mprev = 0;
    for (int i = 0; i < 2048; i++) begin vram[i] = '0; font_rom[i] = '0; end
    for (int i = 0; i < HMAX; i++) begin
      pend[i].valid = 0; exp_rgb[i] = '0; exp_tim[i] = '0;
    end
    for (int i = 0; i < 16; i++) mpal[i] = {3{4'(i)}};
    idle_stim(); st.rn = 0;
    apply_stim();
    test_reset();
    test_glyph();
    test_invert();
    test_palette_hazard();
    test_cursor();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/text_pixel_pipeline.md
TEXT_PIXEL_PIPELINE -- requirements
Module: text_pixel_pipeline

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is synchronous and active-low.
REQ-002 The block SHALL have these parameters:
- COLS, default 80, text columns (even).
- ROWS, default 30, text rows.
- VRAM_AW, default 11, VRAM word address width.
REQ-003 The block SHALL have these ports:
- axi_aclk  in  1  pixel/system clock.
- axi_aresetn  in  1  synchronous active-low reset.
- drawX, drawY  in  10 each  pixel coordinates.
- vde_in, hsync_in, vsync_in  in  1 each  raw video timing.
- vram_addr  out  VRAM_AW  registered VRAM word address.
- vram_rdata  in  32  VRAM word; 1-cycle synchronous read.
- font_addr  out  11  registered font ROM address.
- font_data  in  8  font row; 1-cycle synchronous read.
- pal_we  in  1  palette write strobe.
- pal_idx  in  4  palette write index.
- pal_data  in  12  palette write RGB, {R,G,B} 4 bits each.
- cursor_en  in  1  cursor enable.
- cursor_col  in  7  cursor cell column.
- cursor_row  in  5  cursor cell row.
- red, green, blue  out  4 each  pixel colour.
- vde_out, hsync_out, vsync_out  out  1 each  delayed timing.

Function
REQ-004 Cell geometry SHALL be 8x16: col=drawX[9:3], row=drawY[9:4], gx=drawX[2:0], gy=drawY[3:0].
REQ-005 vram_addr SHALL be row*(COLS/2)+col/2, registered.
- An input sampled in cycle N SHALL produce vram_addr in cycle N+1.
- vram_rdata for it SHALL be expected in cycle N+2.
REQ-006 Character selection SHALL use the registered col[0]: 0 selects vram_rdata[15:0], 1 selects [31:16].
REQ-007 Each 16-bit character SHALL be decoded as [15] invert, [14:8] code, [7:4] FG index, [3:0] BG index.
REQ-008 font_addr SHALL be {code, gy}, registered, valid in cycle N+3; font_data is sampled in cycle N+4.
REQ-009 The pixel bit SHALL be font_data[7-gx] XOR invert.
- Bit 1 SHALL select palette[FG]; bit 0 SHALL select palette[BG].
REQ-010 red/green/blue SHALL be registered and valid in cycle N+5; the fixed latency is 5 cycles.
REQ-011 vde, hsync and vsync SHALL pass through a 5-stage delay so they stay aligned with RGB.
REQ-012 RGB SHALL be 0 when the delayed vde is 0.
- RGB SHALL also be 0 when col>=COLS or row>=ROWS; the VRAM read is don't-care in that case.
REQ-013 The palette SHALL be 16x12-bit registers.
- pal_we in cycle M SHALL write palette[pal_idx] at the end of cycle M.
- A pixel colour-resolved in cycle M SHALL use the old value.
REQ-014 Cursor: when cursor_en=1, col==cursor_col, row==cursor_row, gy in {14,15} and the cursor is visible, the pixel bit SHALL be forced to 1 (FG colour).
REQ-015 Cursor coordinates SHALL be sampled with the pixel in cycle N and pipelined alongside it.
REQ-016 All comparisons SHALL be unsigned.
- Address arithmetic SHALL be truncated to VRAM_AW bits.
- Wrap-around in the VRAM is not checked.

Reset
REQ-017 While axi_aresetn=0 at a clock edge, the following SHALL be cleared:
- all pipeline registers, vram_addr, font_addr, RGB, vde_out, hsync_out and vsync_out SHALL go to 0.
- the blink counter SHALL go to 0.
REQ-018 Reset SHALL load palette[i]={i,i,i} (a greyscale ramp).
REQ-019 After reset deasserts mid-frame, vde_out SHALL stay 0 for 5 cycles.
- No stale pixel data SHALL appear after that.
- pal_we SHALL be ignored during reset.

Configuration
REQ-020 With macro TEXT_CURSOR_BLINK_EN defined, the blink counter SHALL behave as follows:
- A 6-bit frame counter increments on each vsync_in rising edge (registered edge detect) and wraps from 63 to 0.
- The cursor is visible only when counter[5]=0.
REQ-021 Without TEXT_CURSOR_BLINK_EN, the frame counter SHALL NOT be built and the cursor SHALL be visible whenever cursor_en=1.

Verification
REQ-022 Reset: drive a VRAM word 0x0041_8F41 and hold axi_aresetn low -> outputs are 0, and palette[15] reads 0xFFF via pixel.
REQ-023 Glyph: drive drawX=8 (col 1, upper half), code 0x41, FG 15, BG 0, font_data=0x80 -> in cycle N+5 RGB=0xFFF at gx=0 and RGB=0x000 at gx=1.
REQ-024 Invert: set char[15]=1 with the same data -> the colours swap.
- Also check vde_in=0 -> RGB=0 with the latency preserved.
REQ-025 Palette hazard: pal_we with idx 15, data 0x0F0 in the same cycle a FG-15 pixel resolves -> that pixel is 0xFFF and the next is 0x0F0.
REQ-026 Cursor: cursor_en=1 at (2,3) with drawY=63 (gy=15).
- The pixel is FG.
- With TEXT_CURSOR_BLINK_EN, after 32 vsync pulses the pixel is glyph-driven; after 64 pulses it is FG again.
